digit_serial_addsub: RTL and testbench
======================================

Name: digit_serial_addsub

Overview:
Parameterised multi-cycle adder/subtractor, generalising the 2-bit dataflow adder to WIDTH bits. Operands are captured through a valid/ready handshake and processed DIGIT bits per clock with a registered ripple carry. The result is held under output backpressure. Intended as the shared arithmetic unit for area-constrained datapaths, where one narrow adder slice is reused over several cycles.

Parameters:
WIDTH, 8, operand/result width in bits; WIDTH >= 1
DIGIT, 2, bits added per clock; WIDTH must be an exact multiple of DIGIT; NDIG = WIDTH/DIGIT digit cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and mode valid
in_ready  output  1  unit can accept operands (IDLE only)
x  input  WIDTH  operand A, unsigned or two's complement
y  input  WIDTH  operand B
cin  input  1  carry-in (add) or borrow-in (sub)
sub  input  1  0: x+y+cin; 1: x-y-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result modulo 2^WIDTH
carry  output  1  raw carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset: state=IDLE, out_valid=0, sum=0, carry=0, overflow=0, internal carry/count/operand regs=0. in_ready=0 while rst is high; it rises combinationally when rst deasserts and state is IDLE.
- Effective operation: b = sub ? ~y : y; c0 = sub ? ~cin : cin; result = x + b + c0 over WIDTH+1 bits.
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge E0: latch x, b, c0 into shift registers, clear count, go to RUN.
- RUN:
  - in_ready=0; inputs x/y/cin/sub/in_valid are ignored.
  - On each edge, add the low DIGIT bits of the operand regs plus the carry reg. Shift the DIGIT-bit result into the top of the sum shift reg, store the new carry, shift the operand regs right by DIGIT, and increment count.
  - On the edge completing digit NDIG-1: latch carry and overflow, go to DONE.
- Latency: out_valid rises exactly NDIG clock edges after the accept edge E0 (DIGIT=WIDTH gives 1 cycle).
- DONE:
  - out_valid=1; sum/carry/overflow remain stable.
  - Held indefinitely while out_ready=0.
  - On out_valid&&out_ready: return to IDLE, out_valid=0 after the edge.
  - sum/carry/overflow keep their last value until the next result.
  - No same-cycle accept: in_ready first rises in the cycle after the result handshake.
- Throughput: one operation per NDIG+2 cycles minimum.
- out_ready outside DONE: ignored.
- Reset mid-operation: asserting rst in RUN or DONE immediately clears out_valid and all outputs and discards the operation. No partial result is ever presented.
- Carry-chain widths: the carry reg is 1 bit; the internal digit adder is DIGIT+1 bits wide; no truncation other than the final mod 2^WIDTH.
- Overflow extraction: overflow needs carry into the MSB. Extract it during the final digit cycle as (bit WIDTH-1 of the digit sum) XOR x[msb] XOR b[msb].

Test Plan:
- WIDTH=8, DIGIT=2, add: x=0xFF, y=0x01, cin=0, sub=0 -> sum=0x00, carry=1, overflow=0. out_valid rises exactly 4 edges after accept; in_ready=0 throughout.
- Add overflow: x=0x7F, y=0x01, cin=0 -> sum=0x80, carry=0, overflow=1. Also x=0x80, y=0x80 -> sum=0x00, carry=1, overflow=1.
- Subtract: x=0x05, y=0x07, cin=0, sub=1 -> sum=0xFE, carry=0 (borrow), overflow=0. Also x=0x10, y=0x01, cin=1, sub=1 -> sum=0x0E, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/x/y. Outputs must stay constant and in_ready=0. Raise out_ready -> out_valid drops after 1 edge; in_ready rises the next cycle.
- Reset mid-RUN: accept x=0xAA, y=0x55, assert rst after 2 edges. out_valid/sum/carry clear at once, with no spurious out_valid later. After release, accept x=0x01, y=0x02 -> sum=0x03 after 4 edges.
- Parameter sweep: WIDTH=4, DIGIT=1 (4-cycle latency) and WIDTH=8, DIGIT=8 (1-cycle latency). Run exhaustive/random x, y, cin, sub against the reference model x+b+c0, checking sum, carry and overflow for every vector.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle adder/subtractor, DIGIT bits per clock.
// One narrow adder slice reused over NDIG cycles with a registered carry.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   x, y, cin, sub    operands; sub=1 computes x-y-cin
//   out_valid/ready   result handshake, result held under backpressure
//   sum, carry        result mod 2^WIDTH, raw carry out of MSB
//   overflow          two's-complement overflow
module digit_serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] xr, br, sr, sr_nx, sum_q;
   logic             cr, carry_q, ovf_q;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;
   logic             last, msb_cin;

   assign dsum = {1'b0, xr[DIGIT-1:0]}
               + {1'b0, br[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, cr};

   // New digit enters at the top; widened first so DIGIT==WIDTH works.
   assign sr_nx = WIDTH'({dsum[DIGIT-1:0], sr} >> DIGIT);

   assign last = (cnt == LAST);

   // On the final digit the operand regs hold the MSBs, so the carry
   // into bit WIDTH-1 falls out of the digit sum's top bit.
   assign msb_cin = dsum[DIGIT-1] ^ xr[DIGIT-1] ^ br[DIGIT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xr      <= '0;
         br      <= '0;
         cr      <= 1'b0;
         sr      <= '0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         xr  <= x;
         br  <= sub ? ~y : y;
         cr  <= sub ? ~cin : cin;
         sr  <= '0;
         cnt <= '0;
      end else if (state == RUN) begin
         xr  <= xr >> DIGIT;
         br  <= br >> DIGIT;
         cr  <= dsum[DIGIT];
         sr  <= sr_nx;
         cnt <= cnt + CW'(1);
         if (last) begin
            sum_q   <= sr_nx;
            carry_q <= dsum[DIGIT];
            ovf_q   <= msb_cin ^ dsum[DIGIT];
         end
      end
   end

   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed table, corner sequences and random
// operations on three parameterisations against an arithmetic model.
module tb_digit_serial_addsub;

   logic       clk;
   logic       rst;
   logic [7:0] xv, yv;
   logic       cinv, subv, out_ready;

   logic       iv_a, ir_a, ov_a, c_a, v_a;
   logic [7:0] sum_a;
   logic       iv_b, ir_b, ov_b, c_b, v_b;
   logic [3:0] sum_b;
   logic       iv_c, ir_c, ov_c, c_c, v_c;
   logic [7:0] sum_c;

   int errors = 0;
   int checks = 0;

   digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv_a), .in_ready(ir_a),
      .x(xv), .y(yv), .cin(cinv), .sub(subv),
      .out_valid(ov_a), .out_ready(out_ready),
      .sum(sum_a), .carry(c_a), .overflow(v_a)
   );

   digit_serial_addsub #(.WIDTH(4), .DIGIT(1)) dut_w4 (
      .clk(clk), .rst(rst),
      .in_valid(iv_b), .in_ready(ir_b),
      .x(xv[3:0]), .y(yv[3:0]), .cin(cinv), .sub(subv),
      .out_valid(ov_b), .out_ready(out_ready),
      .sum(sum_b), .carry(c_b), .overflow(v_b)
   );

   digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
      .clk(clk), .rst(rst),
      .in_valid(iv_c), .in_ready(ir_c),
      .x(xv), .y(yv), .cin(cinv), .sub(subv),
      .out_valid(ov_c), .out_ready(out_ready),
      .sum(sum_c), .carry(c_c), .overflow(v_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       v;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic get_ir(input int s);
      case (s)
         0:       return ir_a;
         1:       return ir_b;
         default: return ir_c;
      endcase
   endfunction

   function automatic logic get_ov(input int s);
      case (s)
         0:       return ov_a;
         1:       return ov_b;
         default: return ov_c;
      endcase
   endfunction

   // {overflow, carry, sum zero-extended to 8 bits}
   function automatic logic [9:0] get_res(input int s);
      case (s)
         0:       return {v_a, c_a, sum_a};
         1:       return {v_b, c_b, 4'h0, sum_b};
         default: return {v_c, c_c, sum_c};
      endcase
   endfunction

   task automatic set_iv(input int s, input logic v);
      iv_a = (s == 0) ? v : 1'b0;
      iv_b = (s == 1) ? v : 1'b0;
      iv_c = (s == 2) ? v : 1'b0;
   endtask

   // Plain arithmetic: unsigned sum for sum/carry, signed range for overflow.
   function automatic logic [9:0] model(input int w, input int a,
                                        input int b, input bit ci,
                                        input bit sb);
      int mask, bb, r, sa, sbv, t, lo, hi;
      logic [7:0] s8;
      logic c, v;
      mask = (1 << w) - 1;
      a    = a & mask;
      b    = b & mask;
      bb   = sb ? (~b & mask) : b;
      r    = a + bb + ((sb ? !ci : ci) ? 1 : 0);
      s8   = 8'(r & mask);
      c    = ((r >> w) & 1) != 0;
      sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sbv  = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      t    = sb ? sa - sbv - (ci ? 1 : 0) : sa + sbv + (ci ? 1 : 0);
      hi   = (1 << (w - 1)) - 1;
      lo   = -(1 << (w - 1));
      v    = (t > hi) || (t < lo);
      return {v, c, s8};
   endfunction

   // Accept one operation and wait (bounded) for out_valid.
   task automatic start_wait(input int s, input logic [7:0] a, b,
                             input logic ci, sb,
                             output int lat, output bit busy_ok);
      int n;
      n = 0;
      while (!get_ir(s) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      xv = a; yv = b; cinv = ci; subv = sb;
      set_iv(s, 1'b1);
      @(posedge clk); #1;
      set_iv(s, 1'b0);
      xv   = 8'($urandom);
      yv   = 8'($urandom);
      cinv = 1'($urandom);
      subv = 1'($urandom);
      lat = 0;
      busy_ok = 1'b1;
      while (!get_ov(s) && lat < 40) begin
         if (get_ir(s)) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input int s, input logic [7:0] a, b,
                         input logic ci, sb,
                         output logic [9:0] res, output int lat,
                         output bit busy_ok);
      start_wait(s, a, b, ci, sb, lat, busy_ok);
      res = get_res(s);
      finish_op();
   endtask

   initial begin
      logic [9:0] res, s0;
      int         lat;
      bit         busy_ok, ok;
      logic [7:0] ra, rb;
      logic       rc, rs;

      tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
      tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

      rst = 1'b1;
      xv = '0; yv = '0; cinv = 1'b0; subv = 1'b0;
      out_ready = 1'b0;
      set_iv(0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(ir_a), 32'd0);
      chk("rst_out_valid", 32'(ov_a), 32'd0);
      chk("rst_result", 32'(get_res(0)), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(ir_a), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(0, tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub,
                res, lat, busy_ok);
         chk($sformatf("tbl%0d", i), {14'd0, lat[7:0], res},
             {14'd0, 8'd4, tbl[i].v, tbl[i].c, tbl[i].s});
         chk($sformatf("tbl%0d_busy", i), 32'(busy_ok), 32'd1);
      end

      // Backpressure: result held, inputs ignored, no early accept.
      start_wait(0, 8'h12, 8'h34, 1'b0, 1'b0, lat, busy_ok);
      s0 = get_res(0);
      chk("bp_result", {14'd0, lat[7:0], s0}, {14'd0, 8'd4, 10'h046});
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         iv_a = 1'($urandom);
         xv   = 8'($urandom);
         yv   = 8'($urandom);
         @(posedge clk); #1;
         if (!ov_a || ir_a || get_res(0) !== s0) ok = 1'b0;
      end
      iv_a = 1'b0;
      chk("bp_hold", 32'(ok), 32'd1);
      finish_op();
      chk("bp_ov_drop", 32'(ov_a), 32'd0);
      chk("bp_ready", 32'(ir_a), 32'd1);
      chk("bp_keep", 32'(get_res(0)), 32'h046);

      // Reset in the middle of RUN discards the operation.
      xv = 8'hAA; yv = 8'h55; cinv = 1'b0; subv = 1'b0;
      iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mr_out_valid", 32'(ov_a), 32'd0);
      chk("mr_result", 32'(get_res(0)), 32'd0);
      chk("mr_in_ready", 32'(ir_a), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (ov_a) ok = 1'b0;
      end
      chk("mr_no_spurious", 32'(ok), 32'd1);
      run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, res, lat, busy_ok);
      chk("mr_after", {14'd0, lat[7:0], res}, {14'd0, 8'd4, 10'h003});

      // Random on the default configuration.
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         run_op(0, ra, rb, rc, rs, res, lat, busy_ok);
         chk($sformatf("rnd8x2_%0d", i), {14'd0, lat[7:0], res},
             {14'd0, 8'd4, model(8, int'(ra), int'(rb), rc, rs)});
      end

      // WIDTH=4, DIGIT=1: exhaustive.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int m = 0; m < 4; m++) begin
               run_op(1, 8'(a), 8'(b), m[0], m[1], res, lat, busy_ok);
               chk($sformatf("w4_%0d_%0d_%0d", a, b, m),
                   {14'd0, lat[7:0], res},
                   {14'd0, 8'd4, model(4, a, b, m[0], m[1])});
            end

      // WIDTH=8, DIGIT=8: single-cycle latency.
      for (int i = 0; i < 300; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         run_op(2, ra, rb, rc, rs, res, lat, busy_ok);
         chk($sformatf("d8_%0d", i), {14'd0, lat[7:0], res},
             {14'd0, 8'd1, model(8, int'(ra), int'(rb), rc, rs)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
